user_btn_debounce: RTL and testbench

//  Input-side counterpart of the board's LED output driver: captures the raw,

---
 rtl/user_btn_debounce_if.sv | 27 ++
 rtl/user_btn_debounce.sv | 177 +++++++++++++++++
 tb/tb_user_btn_debounce.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_btn_debounce_if.sv
// Button pins and debounced outputs bundled between board pins and control logic.
// The master drives the raw pins, and the debouncer uses the slave side.
interface user_btn_debounce_if #(
   parameter int BTN_W = 4
);
   logic [BTN_W-1:0] USER_BTN;
   logic [BTN_W-1:0] btn_level;
   logic [BTN_W-1:0] btn_press;
   logic [BTN_W-1:0] btn_release;
   logic [BTN_W-1:0] btn_long;

   modport master (
      output USER_BTN,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_long
   );

   modport slave (
      input  USER_BTN,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_long
   );
endinterface

// File: rtl/user_btn_debounce.sv
// Synchronise and debounce user push-buttons; emit level, press/release pulses.
// Long-press pulses are built only when USER_BTN_LONG_PRESS_EN is defined.
module user_btn_debounce #(
   parameter int DB_CNT_W       = 20,
   parameter int BTN_W          = 4,
   parameter int LP_CNT_W       = 26,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input logic                OSC_50m,
   input logic                FPGA_RSTn,
   user_btn_debounce_if.slave btn_if
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_PEND,
      HELD,
      REL_PEND
   } st_t;

   localparam logic [DB_CNT_W-1:0] DB_MAX   = '1;
   localparam logic [DB_CNT_W-1:0] DB_ONE   = DB_CNT_W'(1);
   localparam logic [BTN_W-1:0]    IDLE_PIN = BTN_ACTIVE_LOW ? '1 : '0;

   logic [1:0]          rst_q;
   logic                rst_n;
   logic [BTN_W-1:0]    sync1_q;
   logic [BTN_W-1:0]    sync2_q;
   logic [BTN_W-1:0]    s;
   st_t                 st_q  [BTN_W];
   st_t                 st_d  [BTN_W];
   logic [DB_CNT_W-1:0] cnt_q [BTN_W];
   logic [DB_CNT_W-1:0] cnt_d [BTN_W];
   logic [BTN_W-1:0]    level_d, press_d, release_d, long_d;
   logic [BTN_W-1:0]    level_q, press_q, release_q, long_q;

   // Reset synchroniser: asserts at once, releases two clocks later.
   always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
      if (!FPGA_RSTn) rst_q <= 2'b00;
      else            rst_q <= {rst_q[0], 1'b1};
   end

   assign rst_n = rst_q[1];
   assign s     = sync2_q ^ IDLE_PIN;

   // State register: pin synchroniser, per-button FSMs, registered outputs.
   always_ff @(posedge OSC_50m or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= IDLE_PIN;
         sync2_q   <= IDLE_PIN;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < BTN_W; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= btn_if.USER_BTN;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         for (int i = 0; i < BTN_W; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Next state: a level must hold DB_MAX+1 cycles in a pend state to commit.
   always_comb begin
      for (int i = 0; i < BTN_W; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         unique case (st_q[i])
            IDLE: begin
               if (s[i]) begin
                  st_d[i]  = PRESS_PEND;
                  cnt_d[i] = '0;
               end
            end
            PRESS_PEND: begin
               if (!s[i]) begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DB_MAX) begin
                  st_d[i]  = HELD;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + DB_ONE;
               end
            end
            HELD: begin
               if (!s[i]) begin
                  st_d[i]  = REL_PEND;
                  cnt_d[i] = '0;
               end
            end
            REL_PEND: begin
               if (s[i]) begin
                  st_d[i]  = HELD;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DB_MAX) begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + DB_ONE;
               end
            end
            default: begin
               st_d[i]  = IDLE;
               cnt_d[i] = '0;
            end
         endcase
      end
   end

   // Outputs: pulses mark committed transitions, level follows committed state.
   always_comb begin
      level_d   = '0;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < BTN_W; i++) begin
         press_d[i]   = (st_q[i] == PRESS_PEND) && (st_d[i] == HELD);
         release_d[i] = (st_q[i] == REL_PEND) && (st_d[i] == IDLE);
         level_d[i]   = (st_d[i] == HELD) || (st_d[i] == REL_PEND);
      end
   end

`ifdef USER_BTN_LONG_PRESS_EN
   localparam logic [LP_CNT_W-1:0] LP_MAX = '1;
   localparam logic [LP_CNT_W-1:0] LP_ONE = LP_CNT_W'(1);

   logic [LP_CNT_W-1:0] lp_q [BTN_W];
   logic [BTN_W-1:0]    lp_done_q;
   logic [BTN_W-1:0]    lp_act;

   // Long press fires once when the saturated counter is first seen.
   always_comb begin
      long_d = '0;
      lp_act = '0;
      for (int i = 0; i < BTN_W; i++) begin
         lp_act[i] = (st_q[i] == HELD) || (st_q[i] == REL_PEND);
         long_d[i] = lp_act[i] && (lp_q[i] == LP_MAX) && !lp_done_q[i];
      end
   end

   // Hold-time counter: saturates, survives release bounces, clears in IDLE.
   always_ff @(posedge OSC_50m or negedge rst_n) begin
      if (!rst_n) begin
         lp_done_q <= '0;
         for (int i = 0; i < BTN_W; i++) lp_q[i] <= '0;
      end else begin
         for (int i = 0; i < BTN_W; i++) begin
            if (st_d[i] == IDLE) begin
               lp_q[i]      <= '0;
               lp_done_q[i] <= 1'b0;
            end else if (lp_act[i]) begin
               if (lp_q[i] != LP_MAX) lp_q[i] <= lp_q[i] + LP_ONE;
               if (long_d[i]) lp_done_q[i] <= 1'b1;
            end
         end
      end
   end
`else
   assign long_d = '0;
`endif

   assign btn_if.btn_level   = level_q;
   assign btn_if.btn_press   = press_q;
   assign btn_if.btn_release = release_q;
   assign btn_if.btn_long    = long_q;

endmodule

// File: tb/tb_user_btn_debounce.sv
// Bench for user_btn_debounce: window-based reference model plus directed
// timing checks and randomized bouncing buttons.
module tb_user_btn_debounce;

   localparam int NB     = 4;
   localparam int DB_MAX = 15;
   localparam int LP_MAX = 63;
   localparam int WIN    = DB_MAX + 2;

   logic       clk;
   logic       FPGA_RSTn;
   logic [3:0] btn;

   user_btn_debounce_if #(.BTN_W(NB)) bif ();

   assign bif.USER_BTN = btn;

   user_btn_debounce #(
      .BTN_W         (NB),
      .DB_CNT_W      (4),
      .LP_CNT_W      (6),
      .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .OSC_50m  (clk),
      .FPGA_RSTn(FPGA_RSTn),
      .btn_if   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: a level commits once the pressed/released state seen
   // by the logic has been steady for DB_MAX+2 samples (two synchroniser
   // stages of delay ahead of it). History holds raw samples since reset.
   logic [3:0] hq [$];
   logic [3:0] m_level = '0;
   logic [3:0] m_press = '0;
   logic [3:0] m_rel   = '0;
   logic [3:0] m_long  = '0;
   int         rst_cnt = 0;
   int         held_n [NB];

   always @(posedge clk) begin
      logic [3:0] prev;
      bit         stable;
      cyc++;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      if (!FPGA_RSTn) begin
         rst_cnt = 0;
         hq.delete();
         m_level = '0;
         for (int b = 0; b < NB; b++) held_n[b] = 0;
      end else if (rst_cnt < 2) begin
         rst_cnt++;
      end else begin
         hq.push_back(~btn);
         if (hq.size() > WIN + 2) void'(hq.pop_front());
         prev = m_level;
         for (int b = 0; b < NB; b++) begin
            if (hq.size() == WIN + 2) begin
               stable = 1'b1;
               for (int j = 0; j < WIN; j++)
                  if (hq[j][b] == prev[b]) stable = 1'b0;
               if (stable) begin
                  m_level[b] = ~prev[b];
                  if (m_level[b]) m_press[b] = 1'b1;
                  else            m_rel[b]   = 1'b1;
               end
            end
            if (prev[b]) begin
               held_n[b]++;
`ifdef USER_BTN_LONG_PRESS_EN
               if (held_n[b] == LP_MAX + 1) m_long[b] = 1'b1;
`endif
            end else begin
               held_n[b] = 0;
            end
         end
      end
   end

   int         press_cnt [NB];
   int         rel_cnt   [NB];
   int         long_cnt  [NB];
   int         press_cyc [NB];
   int         rel_cyc   [NB];
   int         long_cyc  [NB];
   logic [3:0] press_vec_last = '0;
   logic [3:0] rel_vec_last   = '0;

   task automatic cmp(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic check_cycle();
      logic [3:0] el, ep, er, eg;
      el = FPGA_RSTn ? m_level : 4'b0;
      ep = FPGA_RSTn ? m_press : 4'b0;
      er = FPGA_RSTn ? m_rel   : 4'b0;
      eg = FPGA_RSTn ? m_long  : 4'b0;
      cmp("level",   bif.btn_level,   el);
      cmp("press",   bif.btn_press,   ep);
      cmp("release", bif.btn_release, er);
      cmp("long",    bif.btn_long,    eg);
      if (bif.btn_press != 0)   press_vec_last = bif.btn_press;
      if (bif.btn_release != 0) rel_vec_last   = bif.btn_release;
      for (int b = 0; b < NB; b++) begin
         if (bif.btn_press[b])   begin press_cnt[b]++; press_cyc[b] = cyc; end
         if (bif.btn_release[b]) begin rel_cnt[b]++;   rel_cyc[b]   = cyc; end
         if (bif.btn_long[b])    begin long_cnt[b]++;  long_cyc[b]  = cyc; end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         btn = v;
         tick();
      end
   endtask

   function automatic int all_pulses();
      int sum = 0;
      for (int b = 0; b < NB; b++) sum += press_cnt[b] + rel_cnt[b] + long_cnt[b];
      return sum;
   endfunction

   initial begin
      int         t0, snap, snap2;
      logic [3:0] val;
      int         rem [NB];

      for (int b = 0; b < NB; b++) begin
         press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
         press_cyc[b] = -1; rel_cyc[b] = -1; long_cyc[b] = -1;
      end
      FPGA_RSTn = 1'b0;
      btn       = 4'hF;
      @(posedge clk);
      #2;

      // Reset held while pins toggle: outputs stay quiet.
      for (int i = 0; i < 10; i++) begin
         btn = 4'($urandom);
         tick();
      end
      chk_int("reset_outputs",
              {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long}, 0);
      FPGA_RSTn = 1'b1;
      snap = all_pulses();
      run(4'hF, 100);
      chk_int("idle_no_pulses", all_pulses() - snap, 0);

      // Clean press and release of btn0.
      t0 = cyc;
      run(4'b1110, 30);
      chk_int("press0_edge", press_cyc[0], t0 + 19);
      chk_int("press0_level", int'(bif.btn_level[0]), 1);
      t0 = cyc;
      run(4'hF, 30);
      chk_int("release0_edge", rel_cyc[0], t0 + 19);
      chk_int("release0_level", int'(bif.btn_level[0]), 0);

      // Bounced press on btn1, then a 15-cycle glitch.
      snap = press_cnt[1];
      run(4'b1101, 10);
      run(4'hF, 2);
      t0 = cyc;
      run(4'b1101, 30);
      chk_int("bounce_press_count", press_cnt[1] - snap, 1);
      chk_int("bounce_press_edge", press_cyc[1], t0 + 19);
      run(4'hF, 30);
      snap  = press_cnt[1];
      snap2 = rel_cnt[1];
      run(4'b1101, 15);
      run(4'hF, 40);
      chk_int("glitch_press", press_cnt[1] - snap, 0);
      chk_int("glitch_release", rel_cnt[1] - snap2, 0);

      // Simultaneous presses, then release btn2 alone.
      t0 = cyc;
      run(4'b0000, 30);
      cmp("simul_press_vec", press_vec_last, 4'b1111);
      for (int b = 0; b < NB; b++)
         chk_int($sformatf("simul_press_edge%0d", b), press_cyc[b], t0 + 19);
      run(4'b0100, 30);
      cmp("btn2_release_vec", rel_vec_last, 4'b0100);
      run(4'hF, 30);

      // Reset while btn0 is held: fresh press, no release for the aborted one.
      run(4'b1110, 30);
      snap = rel_cnt[0];
      FPGA_RSTn = 1'b0;
      run(4'b1110, 3);
      chk_int("midreset_level", int'(bif.btn_level), 0);
      FPGA_RSTn = 1'b1;
      t0 = cyc;
      run(4'b1110, 40);
      chk_int("midreset_press_edge", press_cyc[0], t0 + 21);
      chk_int("midreset_no_release", rel_cnt[0] - snap, 0);
      run(4'hF, 30);

      // Long hold of btn0.
      snap = long_cnt[0];
      t0   = cyc;
      run(4'b1110, 200);
      chk_int("long_press_edge", press_cyc[0], t0 + 19);
`ifdef USER_BTN_LONG_PRESS_EN
      chk_int("long_count", long_cnt[0] - snap, 1);
      chk_int("long_edge", long_cyc[0], t0 + 19 + LP_MAX + 1);
`else
      chk_int("long_count", long_cnt[0] - snap, 0);
`endif
      run(4'hF, 30);

      // Randomized bouncing on all buttons, one reset in the middle.
      val = 4'hF;
      for (int b = 0; b < NB; b++) rem[b] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NB; b++) begin
            if (rem[b] == 0) begin
               val[b] = ~val[b];
               rem[b] = ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(60, 120)) :
                        int'($urandom_range(1, 25));
            end
            rem[b]--;
         end
         FPGA_RSTn = !(i >= 1500 && i < 1504);
         btn = val;
         tick();
      end
      FPGA_RSTn = 1'b1;
      run(4'hF, 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
